// File: rtl/ft245_pkg.sv
// Shared FSM encodings and default geometry for the FT245-style FIFO responder.
package ft245_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;
  localparam int DEFAULT_T_PRE      = 2;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ACTIVE = 2'd1,
    RD_PRE    = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_ACTIVE = 2'd1,
    WR_PRE    = 2'd2
  } wr_state_t;

  typedef struct packed {
    rd_state_t rd;
    wr_state_t wr;
  } side_state_t;

endpackage

// File: rtl/ft245_sync_fifo.sv
// Single-clock circular buffer with occupancy count; DEPTH must be a power of 2
// so the pointers wrap naturally.
module ft245_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE      = (AW + 1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ft245_fifo_responder.sv
// Device side of an FT245-style async FIFO bus: host strobes read/write bytes,
// a local source fills the RX buffer and a local sink drains the TX buffer.
module ft245_fifo_responder
  import ft245_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int T_PRE      = DEFAULT_T_PRE
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    oFIFO_RXF_n,
  input  logic                    iFIFO_RD_n,
  output logic [DATA_WIDTH-1:0]   oFIFO_RD_DATA,
  output logic                    oFIFO_RD_OE,
  output logic                    oFIFO_TXE_n,
  input  logic                    iFIFO_WR_n,
  input  logic [DATA_WIDTH-1:0]   iFIFO_WR_DATA,
  input  logic [DATA_WIDTH-1:0]   iSRC_DATA,
  input  logic                    iSRC_VALID,
  output logic                    oSRC_READY,
  output logic [DATA_WIDTH-1:0]   oSNK_DATA,
  output logic                    oSNK_VALID,
  input  logic                    iSNK_READY,
  output logic [$clog2(DEPTH):0]  oRX_COUNT,
  output logic [$clog2(DEPTH):0]  oTX_COUNT,
  output logic                    oPROTO_ERR,
  output side_state_t             dbg_state
);

  localparam int PW = (T_PRE > 1) ? $clog2(T_PRE + 1) : 1;
  localparam logic [PW-1:0] PRE_LOAD = PW'(T_PRE - 1);

  // Handshake rule (source and sink): a word moves on a clock edge where
  // valid and ready are both high; ready never depends on valid.

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;
  logic [PW-1:0] rd_pre_cnt, wr_pre_cnt;
  logic rd_prev, wr_prev, rd_armed, wr_armed;
  logic rd_fall, rd_rise, wr_fall, wr_rise;
  logic rd_err, wr_err;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_WIDTH-1:0] rx_head, tx_head;

  // A strobe held low through reset only counts once it has been seen high.
  assign rd_fall = rd_armed & rd_prev & ~iFIFO_RD_n;
  assign rd_rise = ~rd_prev & iFIFO_RD_n;
  assign wr_fall = wr_armed & wr_prev & ~iFIFO_WR_n;
  assign wr_rise = ~wr_prev & iFIFO_WR_n;

  assign oFIFO_RXF_n = (rd_state != RD_IDLE) | rx_empty;
  assign oFIFO_TXE_n = (wr_state != WR_IDLE) | tx_full;
  assign oFIFO_RD_OE = (rd_state == RD_ACTIVE);
  assign oSRC_READY  = ~rx_full;
  assign rx_push     = iSRC_VALID & oSRC_READY;
  assign oSNK_VALID  = ~tx_empty;
  assign oSNK_DATA   = tx_head;
  assign tx_pop      = oSNK_VALID & iSNK_READY;
  assign dbg_state   = '{rd: rd_state, wr: wr_state};

  always_comb begin
    rd_next = rd_state;
    rx_pop  = 1'b0;
    rd_err  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (rd_fall) begin
          if (!rx_empty) rd_next = RD_ACTIVE;
          else           rd_err  = 1'b1;
        end
      end
      RD_ACTIVE: begin
        if (rd_rise) begin
          rd_next = RD_PRE;
          rx_pop  = 1'b1;
        end
      end
      RD_PRE: begin
        if (rd_pre_cnt == '0) rd_next = RD_IDLE;
        if (rd_fall)          rd_err  = 1'b1;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_next = wr_state;
    tx_push = 1'b0;
    wr_err  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (wr_fall) begin
          if (!tx_full) begin
            wr_next = WR_ACTIVE;
            tx_push = 1'b1;
          end else begin
            wr_err = 1'b1;
          end
        end
      end
      WR_ACTIVE: begin
        if (wr_rise) wr_next = WR_PRE;
      end
      WR_PRE: begin
        if (wr_pre_cnt == '0) wr_next = WR_IDLE;
        if (wr_fall)          wr_err  = 1'b1;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state      <= RD_IDLE;
      wr_state      <= WR_IDLE;
      rd_pre_cnt    <= '0;
      wr_pre_cnt    <= '0;
      rd_prev       <= 1'b1;
      wr_prev       <= 1'b1;
      rd_armed      <= 1'b0;
      wr_armed      <= 1'b0;
      oFIFO_RD_DATA <= '0;
      oPROTO_ERR    <= 1'b0;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
      rd_prev  <= iFIFO_RD_n;
      wr_prev  <= iFIFO_WR_n;
      rd_armed <= rd_armed | iFIFO_RD_n;
      wr_armed <= wr_armed | iFIFO_WR_n;
      // Latch the head once so the bus value stays put for the whole strobe.
      if (rd_state == RD_IDLE && rd_next == RD_ACTIVE) oFIFO_RD_DATA <= rx_head;
      if (rd_state != RD_PRE && rd_next == RD_PRE)    rd_pre_cnt <= PRE_LOAD;
      else if (rd_state == RD_PRE && rd_pre_cnt != '0) rd_pre_cnt <= rd_pre_cnt - 1'b1;
      if (wr_state != WR_PRE && wr_next == WR_PRE)    wr_pre_cnt <= PRE_LOAD;
      else if (wr_state == WR_PRE && wr_pre_cnt != '0) wr_pre_cnt <= wr_pre_cnt - 1'b1;
      if (rd_err || wr_err || (!iFIFO_RD_n && !iFIFO_WR_n)) oPROTO_ERR <= 1'b1;
    end
  end

  ft245_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (rx_push),
    .push_data (iSRC_DATA),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (oRX_COUNT),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  ft245_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (tx_push),
    .push_data (iFIFO_WR_DATA),
    .pop       (tx_pop),
    .head      (tx_head),
    .count     (oTX_COUNT),
    .full      (tx_full),
    .empty     (tx_empty)
  );

endmodule
